// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Detects load-use hazards, requests an upstream stall and injects an EX bubble.
module ex_operand_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REG_AW      = 5,
  parameter logic [5:0]  BUBBLE_CTRL = 6'h3F
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src_pc,
  input  logic              id_alu_src_imm,
  input  logic [5:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   operand_A,
  output logic [XLEN-1:0]   operand_B,
  output logic [5:0]        ALU_Control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_pc
);

  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   imm_q;
  logic              src_pc_q;
  logic              src_imm_q;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;
  logic              wt_rs1;
  logic              wt_rs2;
  logic              load_bubble;

  assign load_use_stall = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && !flush &&
                          ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                           (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Same-cycle register-file write: capture the value being written this cycle.
  assign wt_rs1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
  assign wt_rs2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);

  assign load_bubble = flush || load_use_stall || !id_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      rs1_val      <= '0;
      rs2_val      <= '0;
      imm_q        <= '0;
      src_pc_q     <= 1'b0;
      src_imm_q    <= 1'b0;
      ALU_Control  <= BUBBLE_CTRL;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (load_bubble) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      rs1_val      <= '0;
      rs2_val      <= '0;
      imm_q        <= '0;
      src_pc_q     <= 1'b0;
      src_imm_q    <= 1'b0;
      ALU_Control  <= BUBBLE_CTRL;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_rd        <= id_rd;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      rs1_val      <= wt_rs1 ? wb_result : id_rs1_data;
      rs2_val      <= wt_rs2 ? wb_result : id_rs2_data;
      imm_q        <= id_imm;
      src_pc_q     <= id_alu_src_pc;
      src_imm_q    <= id_alu_src_imm;
      ALU_Control  <= id_alu_ctrl;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never bypassed.
  always_comb begin
    fwd_rs1 = rs1_val;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1))
      fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1))
      fwd_rs1 = wb_result;
  end

  always_comb begin
    fwd_rs2 = rs2_val;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2))
      fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2))
      fwd_rs2 = wb_result;
  end

  assign operand_A     = src_pc_q  ? ex_pc : fwd_rs1;
  assign operand_B     = src_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: vector table through a scoreboard queue, plus
// hand sequences for load-use stall, flush, write-through and async reset.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src_pc, id_alu_src_imm;
  logic [5:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_result;
  logic        load_use_stall, ex_valid;
  logic [31:0] operand_A, operand_B, ex_store_data, ex_pc;
  logic [5:0]  ALU_Control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .REG_AW(5), .BUBBLE_CTRL(6'h3F)) dut (
    .clock(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src_pc(id_alu_src_pc), .id_alu_src_imm(id_alu_src_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .operand_A(operand_A), .operand_B(operand_B), .ALU_Control(ALU_Control),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc)
  );

  typedef struct {
    logic        valid, fl, sp, si;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [5:0]  ctrl;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wrw;
    logic [31:0] wres;
    logic        chk_ops;
    logic [31:0] ea, eb, es;
    logic [5:0]  ealu;
    logic        ev;
    logic [4:0]  erd;
  } vec_t;

  typedef struct {
    logic        chk_ops;
    logic [31:0] ea, eb, es;
    logic [5:0]  ealu;
    logic        ev;
    logic [4:0]  erd;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic id_idle();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = '0; id_rs2_data = '0;
    id_imm = '0; id_alu_src_pc = 0; id_alu_src_imm = 0; id_alu_ctrl = '0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; flush = 0;
    mem_rd = '0; mem_reg_write = 0; mem_result = '0;
    wb_rd = '0; wb_reg_write = 0; wb_result = '0;
  endtask

  // Drives a valid instruction into ID (no forwarding sources active).
  task automatic id_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [5:0] ctrl, input logic mread);
    id_idle();
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_data = d1; id_rs2_data = d2;
    id_alu_ctrl = ctrl; id_reg_write = 1; id_mem_read = mread;
  endtask

  vec_t vecs[7];

  initial begin
    exp_t e;
    // valid fl sp si rs1 rs2 rd d1 d2 imm pc ctrl mrd mrw mres wrd wrw wres chk ea eb es ealu ev erd
    vecs[0] = '{1,0,0,0, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 32'h100, 6'h00,
                5'd0,0,32'd0, 5'd0,0,32'd0, 1, 32'd5, 32'd7, 32'd7, 6'h00, 1, 5'd4};
    vecs[1] = '{1,0,0,0, 5'd3, 5'd4, 5'd6, 32'h1, 32'h2, 32'd0, 32'h104, 6'h01,
                5'd3,1,32'h11, 5'd3,1,32'h22, 1, 32'h11, 32'h2, 32'h2, 6'h01, 1, 5'd6};
    vecs[2] = '{1,0,0,1, 5'd0, 5'd6, 5'd7, 32'h0, 32'h66, 32'hFFFFFFFC, 32'h108, 6'h02,
                5'd0,1,32'hDEAD, 5'd0,1,32'h77, 1, 32'h0, 32'hFFFFFFFC, 32'h66, 6'h02, 1, 5'd7};
    vecs[3] = '{1,0,1,0, 5'd8, 5'd9, 5'd10, 32'hAA, 32'hBB, 32'd0, 32'h1000, 6'h03,
                5'd9,1,32'h123, 5'd0,0,32'd0, 1, 32'h1000, 32'h123, 32'h123, 6'h03, 1, 5'd10};
    vecs[4] = '{0,0,0,0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0, 32'h10C, 6'h04,
                5'd0,0,32'd0, 5'd0,0,32'd0, 0, 32'h0, 32'h0, 32'h0, 6'h3F, 0, 5'd0};
    vecs[5] = '{1,1,0,0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0, 32'h110, 6'h05,
                5'd0,0,32'd0, 5'd0,0,32'd0, 0, 32'h0, 32'h0, 32'h0, 6'h3F, 0, 5'd0};
    vecs[6] = '{1,0,0,0, 5'd11, 5'd12, 5'd13, 32'h3, 32'h4, 32'd0, 32'h114, 6'h06,
                5'd11,1,32'h44, 5'd12,1,32'h55, 1, 32'h44, 32'h55, 32'h55, 6'h06, 1, 5'd13};

    // Reset with random inputs
    id_idle();
    reset_n = 0;
    id_valid = 1; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
    id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom; id_alu_ctrl = 6'($urandom); id_mem_read = 1; id_reg_write = 1;
    mem_reg_write = 1; mem_rd = 5'($urandom); mem_result = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu", 32'(ALU_Control), 32'h3F);
    chk("rst_opA", operand_A, 32'd0);
    chk("rst_opB", operand_B, 32'd0);
    chk("rst_stall", 32'(load_use_stall), 32'd0);
    chk("rst_rd", 32'(ex_rd), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);

    @(negedge clk);
    reset_n = 1;

    // Vector table through the scoreboard
    for (int i = 0; i < 7; i++) begin
      id_idle();
      id_valid = vecs[i].valid; flush = vecs[i].fl;
      id_alu_src_pc = vecs[i].sp; id_alu_src_imm = vecs[i].si;
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_rd = vecs[i].rd;
      id_uses_rs1 = 1; id_uses_rs2 = 1;
      id_rs1_data = vecs[i].d1; id_rs2_data = vecs[i].d2;
      id_imm = vecs[i].imm; id_pc = vecs[i].pc; id_alu_ctrl = vecs[i].ctrl;
      id_reg_write = 1;
      mem_rd = vecs[i].mrd; mem_reg_write = vecs[i].mrw; mem_result = vecs[i].mres;
      wb_rd = vecs[i].wrd; wb_reg_write = vecs[i].wrw; wb_result = vecs[i].wres;
      e.chk_ops = vecs[i].chk_ops; e.ea = vecs[i].ea; e.eb = vecs[i].eb; e.es = vecs[i].es;
      e.ealu = vecs[i].ealu; e.ev = vecs[i].ev; e.erd = vecs[i].erd;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(e.ev));
        chk($sformatf("v%0d_alu", i), 32'(ALU_Control), 32'(e.ealu));
        chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(e.erd));
        chk($sformatf("v%0d_regwr", i), 32'(ex_reg_write), 32'(e.ev));
        chk($sformatf("v%0d_memrd", i), 32'(ex_mem_read), 32'd0);
        if (e.chk_ops) begin
          chk($sformatf("v%0d_opA", i), operand_A, e.ea);
          chk($sformatf("v%0d_opB", i), operand_B, e.eb);
          chk($sformatf("v%0d_store", i), ex_store_data, e.es);
        end
      end
      @(negedge clk);
    end

    // EX/MEM over MEM/WB, then MEM/WB alone once EX/MEM stops writing
    id_instr(5'd3, 5'd4, 5'd1, 32'h1, 32'h2, 6'h00, 0);
    @(posedge clk); #1;
    mem_rd = 5'd3; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd = 5'd3; wb_reg_write = 1; wb_result = 32'h22;
    #1 chk("prio_mem", operand_A, 32'h11);
    mem_reg_write = 0;
    #1 chk("prio_wb", operand_A, 32'h22);
    @(negedge clk);

    // Load-use: stall, bubble, recapture with EX/MEM forwarding
    id_instr(5'd1, 5'd2, 5'd5, 32'h10, 32'h0, 6'h00, 1);
    @(posedge clk); #1;
    @(negedge clk);
    id_instr(5'd7, 5'd5, 5'd6, 32'h1, 32'h0, 6'h02, 0);
    #1 chk("lu_stall", 32'(load_use_stall), 32'd1);
    @(posedge clk); #1;
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_alu", 32'(ALU_Control), 32'h3F);
    chk("lu_bubble_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    chk("lu_stall_clear", 32'(load_use_stall), 32'd0);
    @(negedge clk);
    mem_rd = 5'd5; mem_reg_write = 1; mem_result = 32'h40;
    @(posedge clk); #1;
    chk("lu_recap_valid", 32'(ex_valid), 32'd1);
    chk("lu_recap_opB", operand_B, 32'h40);
    chk("lu_recap_opA", operand_A, 32'h1);
    chk("lu_recap_alu", 32'(ALU_Control), 32'h02);
    @(negedge clk);

    // Same hazard but rs2 not read: no stall
    id_instr(5'd1, 5'd2, 5'd5, 32'h10, 32'h0, 6'h00, 1);
    @(posedge clk); #1;
    @(negedge clk);
    id_instr(5'd7, 5'd5, 5'd6, 32'h1, 32'h0, 6'h02, 0);
    id_uses_rs2 = 0;
    #1 chk("lu_nouse_stall", 32'(load_use_stall), 32'd0);
    @(posedge clk); #1;
    chk("lu_nouse_valid", 32'(ex_valid), 32'd1);
    @(negedge clk);

    // Flush beats stall
    id_instr(5'd1, 5'd2, 5'd5, 32'h10, 32'h0, 6'h00, 1);
    @(posedge clk); #1;
    @(negedge clk);
    id_instr(5'd5, 5'd2, 5'd6, 32'h1, 32'h0, 6'h02, 0);
    flush = 1;
    #1 chk("fl_stall", 32'(load_use_stall), 32'd0);
    @(posedge clk); #1;
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_alu", 32'(ALU_Control), 32'h3F);
    @(negedge clk);

    // WB write-through at capture, observed with forwarding removed
    id_instr(5'd9, 5'd2, 5'd3, 32'h0, 32'h0, 6'h00, 0);
    wb_rd = 5'd9; wb_reg_write = 1; wb_result = 32'h99;
    @(posedge clk); #1;
    wb_reg_write = 0; wb_result = 32'h0;
    #1 chk("wt_opA", operand_A, 32'h99);
    @(negedge clk);

    // Async reset mid-stall
    id_instr(5'd1, 5'd2, 5'd5, 32'h10, 32'h0, 6'h00, 1);
    @(posedge clk); #1;
    chk("ar_valid_pre", 32'(ex_valid), 32'd1);
    @(negedge clk);
    id_instr(5'd5, 5'd2, 5'd6, 32'h1, 32'h0, 6'h02, 0);
    #1 chk("ar_stall_pre", 32'(load_use_stall), 32'd1);
    reset_n = 0;
    #1;
    chk("ar_stall", 32'(load_use_stall), 32'd0);
    chk("ar_valid", 32'(ex_valid), 32'd0);
    chk("ar_alu", 32'(ALU_Control), 32'h3F);
    chk("ar_opA", operand_A, 32'd0);
    chk("ar_rd", 32'(ex_rd), 32'd0);
    chk("ar_memrd", 32'(ex_mem_read), 32'd0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
